// File: rtl/phase_sequencer_pkg.sv
// Shared types and constants for the phase sequencer and its duration bank.
package phase_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/phase_duration_bank.sv
// Register file of per-phase durations, written a nibble at a time and
// read combinationally by phase index.
module phase_duration_bank
  import phase_sequencer_pkg::*;
#(
  parameter int  NUM_PHASES   = 3,
  parameter int  TIME_W       = 7,
  parameter int  DEFAULT_TIME = 10,
  localparam int PHASE_W      = $clog2(NUM_PHASES)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [PHASE_W-1:0]  wr_phase,
  input  logic                wr_high,
  input  logic [NIBBLE_W-1:0] wr_data,
  input  logic [PHASE_W-1:0]  rd_phase,
  output logic [TIME_W-1:0]   rd_data
);

  localparam int                HIGH_W    = TIME_W - NIBBLE_W;
  localparam logic [TIME_W-1:0] RESET_VAL = TIME_W'(DEFAULT_TIME);

  logic [TIME_W-1:0] dur [NUM_PHASES];

  // NOTE: this array is reset on purpose -- the durations must come back to a
  // known default after reset, so it is built from flops rather than a RAM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHASES; i++) dur[i] <= RESET_VAL;
    end else if (wr_en && (int'(wr_phase) < NUM_PHASES)) begin
      if (wr_high) dur[wr_phase][TIME_W-1:NIBBLE_W] <= wr_data[HIGH_W-1:0];
      else         dur[wr_phase][NIBBLE_W-1:0]      <= wr_data;
    end
  end

  assign rd_data = (int'(rd_phase) < NUM_PHASES) ? dur[rd_phase] : '0;

endmodule

// File: rtl/phase_sequencer.sv
// Programmable multi-phase countdown: steps through NUM_PHASES durations on
// tick1Hz, single pass or repeating, with hold and stop control.
module phase_sequencer
  import phase_sequencer_pkg::*;
#(
  parameter int  NUM_PHASES   = 3,
  parameter int  TIME_W       = 7,
  parameter int  DEFAULT_TIME = 10,
  localparam int PHASE_W      = $clog2(NUM_PHASES)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick1Hz,
  input  logic               cfgWe,
  input  logic [PHASE_W-1:0] cfgPhase,
  input  logic               cfgHigh,
  input  logic [3:0]         dataIn,
  input  logic               start,
  input  logic               stop,
  input  logic               hold,
  input  logic               autoRepeat,
  output logic               trigger,
  output logic [PHASE_W-1:0] phaseEnded,
  output logic [PHASE_W-1:0] phase,
  output logic [TIME_W-1:0]  timeRemaining,
  output logic               busy,
  output logic               done
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(NUM_PHASES - 1);

  state_t             state, state_next;
  logic [PHASE_W-1:0] phase_next, ended_next, rd_phase;
  logic [TIME_W-1:0]  time_next, rd_time;
  logic               trigger_next, done_next, busy_next;
  logic               counting, phase_end, count_down, last_phase;

  // A tick only counts in RUN when no higher-priority control is present.
  assign counting   = (state == RUN) && !stop && !start && !hold && tick1Hz;
  assign phase_end  = counting && (timeRemaining <= TIME_W'(1));
  assign count_down = counting && (timeRemaining >  TIME_W'(1));
  assign last_phase = (phase == LAST_PHASE);
  assign rd_phase   = (phase_end && !last_phase) ? phase + PHASE_W'(1) : '0;

  phase_duration_bank #(
    .NUM_PHASES   (NUM_PHASES),
    .TIME_W       (TIME_W),
    .DEFAULT_TIME (DEFAULT_TIME)
  ) u_bank (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (cfgWe),
    .wr_phase (cfgPhase),
    .wr_high  (cfgHigh),
    .wr_data  (dataIn),
    .rd_phase (rd_phase),
    .rd_data  (rd_time)
  );

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      phase         <= '0;
      phaseEnded    <= '0;
      timeRemaining <= '0;
      trigger       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_next;
      phase         <= phase_next;
      phaseEnded    <= ended_next;
      timeRemaining <= time_next;
      trigger       <= trigger_next;
      busy          <= busy_next;
      done          <= done_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    if (stop) begin
      state_next = IDLE;
    end else if (start) begin
      state_next = RUN;
    end else begin
      case (state)
        RUN: begin
          if (hold) state_next = HOLD;
          else if (phase_end && last_phase && !autoRepeat) state_next = IDLE;
        end
        HOLD: if (!hold) state_next = RUN;
        default: ;
      endcase
    end
  end

  always_comb begin
    phase_next   = phase;
    time_next    = timeRemaining;
    ended_next   = phaseEnded;
    trigger_next = 1'b0;
    done_next    = 1'b0;
    busy_next    = (state_next != IDLE);
    if (stop) begin
      phase_next = '0;
      time_next  = '0;
    end else if (start) begin
      phase_next = '0;
      time_next  = rd_time;
    end else if (phase_end) begin
      trigger_next = 1'b1;
      ended_next   = phase;
      if (!last_phase) begin
        phase_next = phase + PHASE_W'(1);
        time_next  = rd_time;
      end else if (autoRepeat) begin
        phase_next = '0;
        time_next  = rd_time;
      end else begin
        phase_next = '0;
        time_next  = '0;
        done_next  = 1'b1;
      end
    end else if (count_down) begin
      time_next = timeRemaining - TIME_W'(1);
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer: a driver feeds a behavioural model and
// queues expected outputs; a monitor compares them after every clock edge.
module tb_phase_sequencer;

  localparam int N  = 3;
  localparam int TW = 7;
  localparam int DT = 10;
  localparam int PW = $clog2(N);

  logic          clock, reset;
  logic          tick1Hz, cfgWe, cfgHigh, start, stop, hold, autoRepeat;
  logic [PW-1:0] cfgPhase;
  logic [3:0]    dataIn;
  logic          trigger, busy, done;
  logic [PW-1:0] phaseEnded, phase;
  logic [TW-1:0] timeRemaining;

  phase_sequencer #(.NUM_PHASES(N), .TIME_W(TW), .DEFAULT_TIME(DT)) dut (
    .clock(clock), .reset(reset), .tick1Hz(tick1Hz), .cfgWe(cfgWe),
    .cfgPhase(cfgPhase), .cfgHigh(cfgHigh), .dataIn(dataIn), .start(start),
    .stop(stop), .hold(hold), .autoRepeat(autoRepeat), .trigger(trigger),
    .phaseEnded(phaseEnded), .phase(phase), .timeRemaining(timeRemaining),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit tick, start, stop, hold, rep, we, hi;
    int cp, d;
  } stim_t;

  typedef struct {
    bit trig, busy, done;
    int ended, ph, tr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   rep_mode = 0;

  // Model state: "seconds elapsed in the current phase" against the loaded length.
  int m_dur[N];
  bit m_active, m_holding;
  int m_phase, m_loaded, m_elapsed, m_ended;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_dur[i] = DT;
    m_active = 0; m_holding = 0;
    m_phase = 0; m_loaded = 0; m_elapsed = 0; m_ended = 0;
  endfunction

  function automatic exp_t model_step(input stim_t s);
    exp_t e;
    e.trig = 0;
    e.done = 0;
    if (s.stop) begin
      m_active = 0; m_holding = 0; m_phase = 0; m_loaded = 0; m_elapsed = 0;
    end else if (s.start) begin
      m_active = 1; m_holding = 0; m_phase = 0; m_loaded = m_dur[0]; m_elapsed = 0;
    end else if (m_active && m_holding) begin
      if (!s.hold) m_holding = 0;
    end else if (m_active && s.hold) begin
      m_holding = 1;
    end else if (m_active && s.tick) begin
      m_elapsed++;
      if (m_elapsed >= ((m_loaded == 0) ? 1 : m_loaded)) begin
        e.trig = 1;
        m_ended = m_phase;
        m_elapsed = 0;
        if (m_phase < N - 1) begin
          m_phase++;
          m_loaded = m_dur[m_phase];
        end else if (s.rep) begin
          m_phase = 0;
          m_loaded = m_dur[0];
        end else begin
          m_active = 0; m_phase = 0; m_loaded = 0;
          e.done = 1;
        end
      end
    end
    // Writes take effect after this edge's load, so apply them last.
    if (s.we && s.cp < N) begin
      if (s.hi) m_dur[s.cp] = (m_dur[s.cp] % 16) + (s.d % (1 << (TW - 4))) * 16;
      else      m_dur[s.cp] = (m_dur[s.cp] / 16) * 16 + s.d;
    end
    e.ended = m_ended;
    e.ph    = m_phase;
    e.tr    = m_active ? (m_loaded - m_elapsed) : 0;
    e.busy  = m_active;
    return e;
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '{default: 0};
    s.rep = rep_mode;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    @(negedge clock);
    tick1Hz    = s.tick;
    start      = s.start;
    stop       = s.stop;
    hold       = s.hold;
    autoRepeat = s.rep;
    cfgWe      = s.we;
    cfgHigh    = s.hi;
    cfgPhase   = PW'(s.cp);
    dataIn     = 4'(s.d);
    sb.push_back(model_step(s));
  endtask

  task automatic idle(input int n);
    repeat (n) drive(idle_s());
  endtask

  task automatic ticks(input int n);
    stim_t s;
    s = idle_s();
    s.tick = 1;
    repeat (n) begin
      drive(s);
      drive(idle_s());
    end
  endtask

  task automatic do_start();
    stim_t s;
    s = idle_s();
    s.start = 1;
    drive(s);
  endtask

  task automatic do_stop();
    stim_t s;
    s = idle_s();
    s.stop = 1;
    drive(s);
  endtask

  task automatic cfg(input int p, input bit hi, input int d);
    stim_t s;
    s = idle_s();
    s.we = 1; s.cp = p; s.hi = hi; s.d = d;
    drive(s);
  endtask

  task automatic program_dur(input int p, input int v);
    cfg(p, 0, v % 16);
    cfg(p, 1, v / 16);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_trigger"}, int'(trigger), 0);
    check({tag, "_phaseEnded"}, int'(phaseEnded), 0);
    check({tag, "_phase"}, int'(phase), 0);
    check({tag, "_timeRemaining"}, int'(timeRemaining), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
  endtask

  // Monitor: one queued expectation per driven cycle, compared after the edge.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("trigger@%0d", cyc), int'(trigger), int'(e.trig));
      check($sformatf("phaseEnded@%0d", cyc), int'(phaseEnded), e.ended);
      check($sformatf("phase@%0d", cyc), int'(phase), e.ph);
      check($sformatf("timeRemaining@%0d", cyc), int'(timeRemaining), e.tr);
      check($sformatf("busy@%0d", cyc), int'(busy), int'(e.busy));
      check($sformatf("done@%0d", cyc), int'(done), int'(e.done));
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    {tick1Hz, cfgWe, cfgHigh, start, stop, hold, autoRepeat} = '0;
    cfgPhase = '0;
    dataIn   = '0;
    model_reset();
    #12;
    check_cleared("reset");
    @(negedge clock) reset = 1'b0;

    // Default durations: 10 ticks end phase 0 and load phase 1 with 10.
    rep_mode = 0;
    do_start();
    ticks(10);
    do_stop();

    // Nibble writes: 0x25 = 37, then high nibble 0xF truncated to 0x75 = 117.
    cfg(1, 0, 5);
    cfg(1, 1, 2);
    do_start();
    ticks(11);
    cfg(1, 1, 15);
    do_stop();
    do_start();
    ticks(11);
    do_stop();

    // Single pass 2,1,3: triggers after ticks 2, 3, 6 and done on the last.
    program_dur(0, 2);
    program_dur(1, 1);
    program_dur(2, 3);
    do_start();
    ticks(7);

    // Repeat with a zero-length phase: 1,0,1 triggers on every tick.
    program_dur(0, 1);
    program_dur(1, 0);
    program_dur(2, 1);
    rep_mode = 1;
    do_start();
    ticks(8);
    do_stop();
    rep_mode = 0;

    // Hold at 6 for 5 ticks, release, then a stop coinciding with a phase end.
    program_dur(0, 10);
    do_start();
    ticks(4);
    s = idle_s();
    s.hold = 1;
    repeat (5) begin
      s.tick = 1; drive(s);
      s.tick = 0; drive(s);
    end
    idle(1);
    ticks(5);
    s = idle_s();
    s.tick = 1;
    s.stop = 1;
    drive(s);
    idle(2);

    // Randomised traffic against the model.
    begin
      bit hold_lvl;
      hold_lvl = 0;
      for (int i = 0; i < 3000; i++) begin
        s = idle_s();
        if ($urandom_range(0, 19) == 0) hold_lvl = ~hold_lvl;
        if ($urandom_range(0, 49) == 0) rep_mode = ~rep_mode;
        s.rep   = rep_mode;
        s.hold  = hold_lvl;
        s.tick  = ($urandom_range(0, 2) == 0);
        s.start = ($urandom_range(0, 39) == 0);
        s.stop  = ($urandom_range(0, 79) == 0);
        if ($urandom_range(0, 7) == 0) begin
          s.we = 1;
          s.cp = int'($urandom_range(0, (1 << PW) - 1));
          s.hi = bit'($urandom_range(0, 1));
          s.d  = s.hi ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 15));
        end
        drive(s);
      end
    end
    do_stop();

    // Asynchronous reset between edges while running.
    rep_mode = 0;
    program_dur(0, 3);
    program_dur(2, 5);
    do_start();
    ticks(1);
    @(posedge clock);
    #3;
    {tick1Hz, cfgWe, cfgHigh, start, stop, hold, autoRepeat} = '0;
    reset = 1'b1;
    #1;
    check_cleared("async_reset");
    model_reset();
    @(negedge clock) reset = 1'b0;
    do_start();
    ticks(10);
    do_stop();
    idle(2);

    @(posedge clock);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
Parametrised successor to the fixed three-phase timer path. The block holds NUM_PHASES programmable durations, loaded nibble-wise from dataIn, and counts down the active phase once per tick1Hz enable. It advances through the phases automatically, either once or repeating. It drives trigger, the current phase index and timeRemaining to the display/actuator logic.

Parameters:
NUM_PHASES, 3, number of timed phases (2..16)
TIME_W, 7, width of each duration and of timeRemaining (5..8)
DEFAULT_TIME, 10, reset value of every duration register
PHASE_W, $clog2(NUM_PHASES), localparam, width of phase indices

Ports:
clock  input  1  system clock; single clock domain
reset  input  1  asynchronous, active-high reset
tick1Hz  input  1  one-cycle enable pulse, once per second; not a clock
cfgWe  input  1  config write strobe
cfgPhase  input  PHASE_W  target phase of config write
cfgHigh  input  1  0 = write bits [3:0]; 1 = write bits [TIME_W-1:4]
dataIn  input  4  config nibble
start  input  1  pulse: begin the sequence at phase 0
stop  input  1  pulse: abort to IDLE
hold  input  1  level: freeze countdown
autoRepeat  input  1  1 = wrap from last phase to phase 0; 0 = single pass
trigger  output  1  one-cycle pulse at every phase end
phaseEnded  output  PHASE_W  index of the phase that just ended; valid with trigger
phase  output  PHASE_W  active phase
timeRemaining  output  TIME_W  current countdown value
busy  output  1  high in RUN or HOLD
done  output  1  one-cycle pulse when a single-pass sequence completes

Behaviour:
- Reset state (asynchronous): all durations = DEFAULT_TIME; state IDLE; phase, phaseEnded, timeRemaining = 0; trigger, busy, done = 0.
- Config write:
  - cfgWe updates the selected nibble of duration[cfgPhase] at the next edge. For high-nibble writes, dataIn bits above TIME_W-5 are dropped.
  - cfgPhase >= NUM_PHASES: write ignored.
  - Writes are legal in any state. The running counter is unaffected; the new value applies at the next load of that phase.
- FSM states: IDLE, RUN, HOLD.
  - IDLE + start: next edge phase = 0, timeRemaining = duration[0], state RUN, busy = 1.
  - RUN + hold: state HOLD. HOLD + !hold: state RUN. Ticks in HOLD are ignored, not queued.
  - RUN + tick1Hz with timeRemaining > 1: decrement by 1.
  - RUN + tick1Hz with timeRemaining <= 1 (phase end):
    - trigger = 1 and phaseEnded = phase for one cycle.
    - If phase < NUM_PHASES-1: phase += 1 and load duration[phase+1] in the same edge.
    - Else if autoRepeat = 1: phase = 0 and load duration[0].
    - Else: state IDLE, timeRemaining = 0, phase = 0, busy = 0, done = 1 for one cycle.
  - A zero duration behaves as duration 1: the phase ends on the first tick after load.
- stop (any state): next edge state IDLE, timeRemaining = 0, phase = 0; no trigger, no done.
- Priority within one cycle: stop > start > hold > tick1Hz.
  - start in RUN or HOLD restarts from phase 0 and clears hold state. The coincident tick is discarded.
- Latency: every output is registered and updates one edge after its cause.
- autoRepeat is sampled only at the last-phase end.
- A tick1Hz pulse longer than one cycle counts once per cycle. The source must guarantee single-cycle pulses.

Decomposition:
- Shared package: state enum (IDLE, RUN, HOLD) and the nibble-width constant (4).
- Natural sub-module: phase_duration_bank, NUM_PHASES x TIME_W registers with nibble write port and combinational read by index. The FSM and counter stay in the top module.

Test Plan:
- Reset defaults: reset, then start with NUM_PHASES = 3 -> timeRemaining = 10, phase = 0; after 10 ticks, trigger pulse with phaseEnded = 0 and timeRemaining = 10, phase = 1.
- Nibble config: write phase 1 low = 4'h5 and high = 4'h2 (TIME_W = 7) -> duration 37; run to phase 1 -> timeRemaining = 37; write 4'hF to high nibble -> bit 3 dropped, value = 0x75 = 117.
- Single pass: durations 2, 1, 3 with autoRepeat = 0 -> triggers after ticks 2, 3 and 6; done on the third trigger cycle; busy = 0 afterwards.
- Auto repeat and zero duration: durations 1, 0, 1 with autoRepeat = 1 -> trigger on every tick; phase sequence 0, 1, 2, 0, 1...; done never asserted.
- Hold and stop: hold asserted at timeRemaining = 6 for 5 ticks -> stays 6; release plus one tick -> 5. stop in the same cycle as a phase-end tick -> IDLE, no trigger, timeRemaining = 0.
- Asynchronous reset mid-RUN: assert reset between clock edges -> outputs clear immediately without waiting for an edge; programmed durations revert to 10.
